// File: rtl/pipeline_pkg.sv
// Shared pipeline-stage definitions: occupancy width, stage-control bundle,
// and small helpers used by every stage register built on skid buffering.
package pipeline_pkg;

  localparam int OCC_W = 2;

  // Control that every stage register sees from the hazard unit.
  typedef struct packed {
    logic flush;
    logic freeze;
  } stage_ctrl_t;

  // Either control blocks both handshakes this cycle.
  function automatic logic ctrl_blocks(input stage_ctrl_t c);
    return c.flush | c.freeze;
  endfunction

  // Held entry count from the two registered valid bits.
  function automatic logic [OCC_W-1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry: valid bit plus payload, with load (set),
// release (drop) and synchronous clear. Data holds when the entry empties
// so the downstream view stays stable while nothing is presented.
module pipe_entry_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clr_data,
  input  logic             set,
  input  logic             drop,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Clear wins over load; load wins over release; data only moves on load.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= 1'b0;
      if (clr_data) data <= '0;
    end else if (set) begin
      valid <= 1'b1;
      data  <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/skid_stage_register.sv
// Two-entry skid stage register. Main entry drives the output; skid entry
// absorbs the one payload that can arrive while the downstream is stalled,
// so in_ready depends only on registered state plus flush/freeze/rst.
module skid_stage_register
  import pipeline_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  localparam logic CLR_DATA_ON_FLUSH = (CLEAR_ON_FLUSH != 0);

  stage_ctrl_t      ctrl;
  logic             blocked;
  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             accept, emit;
  logic             clr, clr_data;
  logic             main_set, main_drop, skid_set, skid_drop;
  logic [WIDTH-1:0] main_d;

  assign ctrl.flush  = flush;
  assign ctrl.freeze = freeze;
  assign blocked     = ctrl_blocks(ctrl) | rst;

  assign in_ready  = ~skid_valid & ~blocked;
  assign out_valid = main_valid & ~blocked;
  assign out_data  = main_data;
  assign occupancy = occ_count(main_valid, skid_valid);

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Reset always scrubs payloads; flush scrubs them only when configured to.
  assign clr      = rst | flush;
  assign clr_data = rst | (flush & CLR_DATA_ON_FLUSH);

  // Steer the two entries: skid refills main first, otherwise the new
  // payload goes to main if it is (or is becoming) free, else to skid.
  always_comb begin
    main_set  = (~main_valid & accept) | (emit & (skid_valid | accept));
    main_drop = emit & ~skid_valid & ~accept;
    main_d    = skid_valid ? skid_data : in_data;
    skid_set  = main_valid & ~emit & accept;
    skid_drop = emit & skid_valid;
  end

  pipe_entry_reg #(.WIDTH(WIDTH)) u_main (
    .clk      (clk),
    .clr      (clr),
    .clr_data (clr_data),
    .set      (main_set),
    .drop     (main_drop),
    .d        (main_d),
    .valid    (main_valid),
    .data     (main_data)
  );

  pipe_entry_reg #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk),
    .clr      (clr),
    .clr_data (clr_data),
    .set      (skid_set),
    .drop     (skid_drop),
    .d        (in_data),
    .valid    (skid_valid),
    .data     (skid_data)
  );

endmodule

// File: doc/skid_stage_register.md
SKID_STAGE_REGISTER -- requirements
Module: skid_stage_register

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 Parameter CLEAR_ON_FLUSH, default 1; 1 = data registers zeroed on flush, 0 = only valids cleared.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 flush  input  1  drop all held entries (branch taken / hazard squash).
REQ-006 freeze  input  1  stall; hold all state, block both handshakes.
REQ-007 in_valid  input  1  upstream has payload.
REQ-008 in_ready  output  1  stage can accept payload this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  stage presents payload.
REQ-011 out_ready  input  1  downstream accepts payload.
REQ-012 out_data  output  WIDTH  payload presented downstream.
REQ-013 occupancy  output  2  held entry count, 0..2.

Function
REQ-014 Storage SHALL be two entries: main (drives out_data/out_valid) and skid (overflow); each has a valid bit and WIDTH data bits.
REQ-015 Accept SHALL occur on in_valid & in_ready; emit SHALL occur on out_valid & out_ready.
REQ-016 in_ready SHALL equal ~skid_valid & ~freeze & ~flush & ~rst; no combinational path from out_ready or in_valid.
REQ-017 out_valid SHALL equal main_valid & ~freeze & ~flush.
REQ-018 Main empty + accept: main <= in_data; out_valid next cycle (1-cycle latency).
REQ-019 Main full, no emit, accept: skid <= in_data; main unchanged.
REQ-020 Main full, emit, accept, skid empty: main <= in_data.
REQ-021 Main full, emit, skid full (no accept possible): main <= skid, skid emptied.
REQ-022 Main full, emit, no accept, skid empty: main emptied.
REQ-023 Payload order SHALL be preserved; no payload duplicated or dropped except by flush.
REQ-024 Full condition (occupancy 2): in_ready 0; sustained out_ready=1 with in_valid=1 SHALL give one transfer per cycle after drain of one entry.
REQ-025 Freeze: no state change; in_ready and out_valid 0; state resumes unchanged when freeze falls.
REQ-026 Flush: next cycle both valids 0, occupancy 0; any same-cycle in_data is discarded; flush overrides freeze.
REQ-027 CLEAR_ON_FLUSH=1: both data registers zero after flush; =0: data registers hold.
REQ-028 out_data SHALL hold its last value while out_valid is 0, except as cleared by reset/flush.
REQ-029 occupancy SHALL equal main_valid + skid_valid, registered-state derived.

Reset
REQ-030 rst=1 at a clock edge SHALL clear both valids and both data registers to 0, overriding flush, freeze and handshakes.
REQ-031 During rst=1, in_ready and out_valid SHALL be 0; in_ready SHALL be 1 the first cycle after rst falls.
REQ-032 rst asserted mid-transfer SHALL discard all held payloads; no payload emitted afterwards.

Structure
REQ-033 Occupancy width constant and stage-control bundle type (flush, freeze) SHALL live in shared package pipeline_pkg.
REQ-034 One sub-module pipe_entry_reg (WIDTH data + valid, load enable, synchronous clear) SHALL be instantiated twice (main, skid).
REQ-035 Existing per-stage registers (decode, execute, memory) SHALL be replaceable by this block with WIDTH set to their bundle width.

Verification
REQ-036 WIDTH=32; send 0xA5A5_0001 with out_ready=1 -> out_valid next cycle, out_data=0xA5A5_0001, occupancy 1 then 0.
REQ-037 out_ready=0; send 0x11, 0x22 -> occupancy 2, in_ready 0; raise out_ready -> 0x11 then 0x22 in consecutive cycles.
REQ-038 Stream 0..99 with random out_ready/in_valid -> output sequence exactly 0..99, no gaps.
REQ-039 occupancy 2, pulse flush with in_valid=1, in_data=0x33 -> next cycle occupancy 0, out_data=0, 0x33 never emitted.
REQ-040 occupancy 1 holding 0x44, freeze 3 cycles with out_ready=1 -> out_valid 0 throughout, then 0x44 emitted once after freeze falls.
REQ-041 occupancy 2, assert rst one cycle -> occupancy 0, out_valid 0, in_ready 1 the following cycle.
